pcie_lane_channel: RTL and testbench



---
 rtl/pcie_chan_pkg.sv | 12 +
 rtl/pcie_lane_dly.sv | 53 +++++
 rtl/pcie_lane_channel.sv | 179 +++++++++++++++++
 tb/tb_pcie_lane_channel.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_chan_pkg.sv
// Shared types and constants for the PCIe lane channel and its per-lane delay lines.
package pcie_chan_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } chan_state_e;

  localparam logic [9:0] DEFAULT_IDLE_SYM = 10'h000;
  localparam int         LANE_IDX_W       = 4;

endpackage

// File: rtl/pcie_lane_dly.sv
// One lane delay line: circular history of {idle, symbol} with a skew-indexed registered read.
module pcie_lane_dly
  import pcie_chan_pkg::*;
#(
  parameter int         SKEW_W   = 3,
  parameter logic [9:0] IDLE_SYM = DEFAULT_IDLE_SYM
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SKEW_W-1:0] wr_ptr,
  input  logic [SKEW_W-1:0] skew,
  input  logic [9:0]        sym_in,
  input  logic              idle_in,
  output logic [9:0]        sym_out,
  output logic              idle_out
);

  localparam int DEPTH = 1 << SKEW_W;

  logic [10:0]       mem_q [DEPTH];
  logic [10:0]       mem_d [DEPTH];
  logic [10:0]       out_q;
  logic [10:0]       out_d;
  logic [SKEW_W-1:0] rd_idx;

  // Reading the post-write view makes skew 0 forward the symbol being written this edge.
  always_comb begin
    rd_idx = wr_ptr - skew;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    mem_d[wr_ptr] = {idle_in, sym_in};
    out_d = mem_d[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {1'b1, IDLE_SYM};
      end
      out_q <= {1'b1, IDLE_SYM};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      out_q <= out_d;
    end
  end

  assign sym_out  = out_q[9:0];
  assign idle_out = out_q[10];

endmodule

// File: rtl/pcie_lane_channel.sv
// Multi-lane deskew/invert channel with a RUN/FLUSH reconfiguration handshake.
// Error injection is compiled in only when PCIE_CHAN_ERR_INJ_EN is defined.
module pcie_lane_channel
  import pcie_chan_pkg::*;
#(
  parameter int         NUM_LANES = 16,
  parameter int         SKEW_W    = 3,
  parameter logic [9:0] IDLE_SYM  = DEFAULT_IDLE_SYM
) (
  input  logic                    Clk,
  input  logic                    notReset,
  input  logic [NUM_LANES*10-1:0] LinkIn,
  input  logic [NUM_LANES-1:0]    ElecIdleIn,
  output logic [NUM_LANES*10-1:0] LinkOut,
  output logic [NUM_LANES-1:0]    ElecIdleOut,
  input  logic                    LaneReverse,
  input  logic                    CfgValid,
  output logic                    CfgReady,
  input  logic [3:0]              CfgLane,
  input  logic [SKEW_W-1:0]       CfgSkew,
  input  logic                    CfgInvert,
  input  logic [3:0]              ErrLane,
  input  logic [9:0]              ErrMask,
  input  logic [15:0]             ErrPeriod,
  output logic [15:0]             ErrCount
);

  chan_state_e           state_q, state_d;
  logic [SKEW_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [SKEW_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic                  rev_q, rev_d;
  logic                  rdy_en_q, rdy_en_d;
  logic [SKEW_W-1:0]     skew_q [NUM_LANES];
  logic [SKEW_W-1:0]     skew_d [NUM_LANES];
  logic [NUM_LANES-1:0]  inv_q, inv_d;

  logic [9:0]            lane_sym [NUM_LANES];
  logic [NUM_LANES-1:0]  lane_idle;
  logic [9:0]            dly_sym [NUM_LANES];
  logic [NUM_LANES-1:0]  dly_idle;
  logic [9:0]            err_xor [NUM_LANES];
  logic                  cfg_fire;
  logic                  lane_ok;

  assign CfgReady = rdy_en_q && (state_q == ST_RUN);
  assign cfg_fire = CfgValid && CfgReady;
  assign lane_ok  = int'(CfgLane) < NUM_LANES;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wr_ptr_d    = wr_ptr_q + 1'b1;
    rdy_en_d    = 1'b1;
    rev_d       = notReset ? rev_q : LaneReverse;
    skew_d      = skew_q;
    inv_d       = inv_q;
    unique case (state_q)
      ST_RUN: begin
        if (cfg_fire && lane_ok) begin
          for (int l = 0; l < NUM_LANES; l++) begin
            if (CfgLane == LANE_IDX_W'(l)) begin
              skew_d[l] = CfgSkew;
              inv_d[l]  = CfgInvert;
            end
          end
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '1) begin
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    rev_q <= rev_d;
    if (!notReset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rdy_en_q    <= 1'b0;
      inv_q       <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        skew_q[l] <= '0;
      end
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rdy_en_q    <= rdy_en_d;
      inv_q       <= inv_d;
      skew_q      <= skew_d;
    end
  end

  // Reversal is applied on the way in, so skew/invert stay indexed by output lane.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign lane_sym[gi]  = rev_q ? LinkIn[(NUM_LANES-1-gi)*10 +: 10] : LinkIn[gi*10 +: 10];
    assign lane_idle[gi] = rev_q ? ElecIdleIn[NUM_LANES-1-gi] : ElecIdleIn[gi];

    pcie_lane_dly #(
      .SKEW_W   (SKEW_W),
      .IDLE_SYM (IDLE_SYM)
    ) u_dly (
      .clk      (Clk),
      .rst_n    (notReset),
      .wr_ptr   (wr_ptr_q),
      .skew     (skew_q[gi]),
      .sym_in   (lane_sym[gi]),
      .idle_in  (lane_idle[gi]),
      .sym_out  (dly_sym[gi]),
      .idle_out (dly_idle[gi])
    );
  end

`ifdef PCIE_CHAN_ERR_INJ_EN
  logic [15:0] err_cyc_q, err_cyc_d;
  logic [15:0] err_count_q, err_count_d;
  logic        inj_fire;

  always_comb begin
    inj_fire    = (state_q == ST_RUN) && (ErrPeriod != 16'd0) &&
                  (err_cyc_q == ErrPeriod - 16'd1);
    err_cyc_d   = err_cyc_q;
    err_count_d = err_count_q;
    if (state_q == ST_RUN) begin
      err_cyc_d = inj_fire ? 16'd0 : err_cyc_q + 16'd1;
    end
    if (inj_fire && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      err_xor[l] = (inj_fire && (ErrLane == LANE_IDX_W'(l))) ? ErrMask : 10'h000;
    end
  end

  always_ff @(posedge Clk) begin
    if (!notReset) begin
      err_cyc_q   <= '0;
      err_count_q <= '0;
    end else begin
      err_cyc_q   <= err_cyc_d;
      err_count_q <= err_count_d;
    end
  end

  assign ErrCount = err_count_q;
`else
  logic unused_err;
  assign unused_err = ^{ErrLane, ErrMask, ErrPeriod};

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      err_xor[l] = 10'h000;
    end
  end

  assign ErrCount = 16'h0000;
`endif

  // Idle lanes and the whole FLUSH window present a clean idle symbol.
  always_comb begin
    LinkOut     = {NUM_LANES{IDLE_SYM}};
    ElecIdleOut = '1;
    for (int l = 0; l < NUM_LANES; l++) begin
      if ((state_q == ST_RUN) && !dly_idle[l]) begin
        LinkOut[l*10 +: 10] = dly_sym[l] ^ {10{inv_q[l]}} ^ err_xor[l];
        ElecIdleOut[l]      = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcie_lane_channel.sv
// Scoreboard bench for pcie_lane_channel: a cycle-level reference model queues expected outputs.
module tb_pcie_lane_channel;

  localparam int         N    = 4;
  localparam int         W    = 3;
  localparam logic [9:0] IDLE = 10'h000;
`ifdef PCIE_CHAN_ERR_INJ_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic           Clk = 1'b0;
  logic           notReset;
  logic [N*10-1:0] LinkIn;
  logic [N-1:0]   ElecIdleIn;
  logic [N*10-1:0] LinkOut;
  logic [N-1:0]   ElecIdleOut;
  logic           LaneReverse;
  logic           CfgValid;
  logic           CfgReady;
  logic [3:0]     CfgLane;
  logic [W-1:0]   CfgSkew;
  logic           CfgInvert;
  logic [3:0]     ErrLane;
  logic [9:0]     ErrMask;
  logic [15:0]    ErrPeriod;
  logic [15:0]    ErrCount;

  always #5 Clk = ~Clk;

  pcie_lane_channel #(
    .NUM_LANES (N),
    .SKEW_W    (W),
    .IDLE_SYM  (IDLE)
  ) dut (
    .Clk         (Clk),
    .notReset    (notReset),
    .LinkIn      (LinkIn),
    .ElecIdleIn  (ElecIdleIn),
    .LinkOut     (LinkOut),
    .ElecIdleOut (ElecIdleOut),
    .LaneReverse (LaneReverse),
    .CfgValid    (CfgValid),
    .CfgReady    (CfgReady),
    .CfgLane     (CfgLane),
    .CfgSkew     (CfgSkew),
    .CfgInvert   (CfgInvert),
    .ErrLane     (ErrLane),
    .ErrMask     (ErrMask),
    .ErrPeriod   (ErrPeriod),
    .ErrCount    (ErrCount)
  );

  typedef struct {
    int              cyc;
    logic [N*10-1:0] link;
    logic [N-1:0]    eidle;
    logic            rdy;
    logic [15:0]     errc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  // Reference model state: input history by cycle number plus the architectural configuration.
  int         cyc = 1;
  int         last_rst = 0;
  logic [9:0] h_sym  [64][N];
  bit         h_idle [64][N];
  bit         m_rev = 1'b0;
  int         m_skew [N];
  bit         m_inv  [N];
  int         flush_left = 0;
  bit         m_rdy_en = 1'b0;
  int         err_total = 0;
  int         n_run = 0;
  bit         inj_now = 1'b0;

  task automatic step();
    exp_t       e;
    int         k;
    int         src;
    logic [9:0] d_sym [N];
    bit         d_idle [N];
    logic [9:0] s;
    e.cyc = cyc;
    if (!notReset) begin
      last_rst   = cyc;
      m_rev      = LaneReverse;
      flush_left = 0;
      m_rdy_en   = 1'b0;
      err_total  = 0;
      n_run      = 1;
      inj_now    = INJ && (ErrPeriod == 16'd1);
      for (int o = 0; o < N; o++) begin
        m_skew[o] = 0;
        m_inv[o]  = 1'b0;
      end
      e.link  = {N{IDLE}};
      e.eidle = '1;
      e.rdy   = 1'b0;
      e.errc  = 16'd0;
    end else begin
      for (int o = 0; o < N; o++) begin
        h_sym[cyc % 64][o]  = LinkIn[o*10 +: 10];
        h_idle[cyc % 64][o] = ElecIdleIn[o];
      end
      // Each output lane shows the input from skew cycles back (1+skew latency to the sample point).
      for (int o = 0; o < N; o++) begin
        k   = cyc - m_skew[o];
        src = m_rev ? N - 1 - o : o;
        if (k <= last_rst) begin
          d_sym[o]  = IDLE;
          d_idle[o] = 1'b1;
        end else begin
          d_sym[o]  = h_sym[k % 64][src];
          d_idle[o] = h_idle[k % 64][src];
        end
      end
      if (inj_now && err_total < 65535) err_total++;
      if (flush_left > 0) begin
        flush_left--;
      end else if (CfgValid && m_rdy_en && int'(CfgLane) < N) begin
        m_skew[CfgLane] = int'(CfgSkew);
        m_inv[CfgLane]  = CfgInvert;
        flush_left      = 1 << W;
      end
      m_rdy_en = 1'b1;
      if (flush_left == 0) begin
        n_run++;
        inj_now = INJ && (ErrPeriod != 16'd0) && (n_run % int'(ErrPeriod) == 0);
      end else begin
        inj_now = 1'b0;
      end
      e.rdy  = (flush_left == 0);
      e.errc = 16'(err_total);
      for (int o = 0; o < N; o++) begin
        if (flush_left > 0 || d_idle[o]) begin
          e.link[o*10 +: 10] = IDLE;
          e.eidle[o]         = 1'b1;
        end else begin
          s = d_sym[o];
          if (m_inv[o]) s = ~s;
          if (inj_now && int'(ErrLane) == o) s = s ^ ErrMask;
          e.link[o*10 +: 10] = s;
          e.eidle[o]         = 1'b0;
        end
      end
    end
    exp_q.push_back(e);
    cyc++;
    @(negedge Clk);
  endtask

  // Monitor: the DUT presents a result every cycle; pair it with the oldest expectation.
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      tests++;
      if (LinkOut !== mon_e.link) begin
        fails++;
        $display("FAIL link_out cyc=%0d got=%h want=%h", mon_e.cyc, LinkOut, mon_e.link);
      end
      tests++;
      if (ElecIdleOut !== mon_e.eidle) begin
        fails++;
        $display("FAIL elec_idle_out cyc=%0d got=%b want=%b", mon_e.cyc, ElecIdleOut, mon_e.eidle);
      end
      tests++;
      if (CfgReady !== mon_e.rdy) begin
        fails++;
        $display("FAIL cfg_ready cyc=%0d got=%b want=%b", mon_e.cyc, CfgReady, mon_e.rdy);
      end
      tests++;
      if (ErrCount !== mon_e.errc) begin
        fails++;
        $display("FAIL err_count cyc=%0d got=%0d want=%0d", mon_e.cyc, ErrCount, mon_e.errc);
      end
    end
  end

  task automatic rand_link(input int idle_odds);
    for (int l = 0; l < N; l++) begin
      LinkIn[l*10 +: 10] = 10'($urandom);
      ElecIdleIn[l]      = (idle_odds != 0) && ($urandom_range(idle_odds - 1) == 0);
    end
  endtask

  task automatic cfg(input int lane, input int sk, input bit inv);
    int guard = 0;
    while (!(m_rdy_en && flush_left == 0) && guard < 20) begin
      step();
      guard++;
    end
    CfgValid  = 1'b1;
    CfgLane   = 4'(lane);
    CfgSkew   = W'(sk);
    CfgInvert = inv;
    step();
    CfgValid  = 1'b0;
  endtask

  task automatic do_reset(input bit rev, input int cycles);
    notReset    = 1'b0;
    LaneReverse = rev;
    repeat (cycles) step();
    notReset    = 1'b1;
  endtask

  initial begin
    notReset = 1'b0; LaneReverse = 1'b0; LinkIn = '0; ElecIdleIn = '0;
    CfgValid = 1'b0; CfgLane = '0; CfgSkew = '0; CfgInvert = 1'b0;
    ErrLane = 4'd2; ErrMask = 10'h001; ErrPeriod = 16'd4;
    for (int o = 0; o < N; o++) begin
      m_skew[o] = 0;
      m_inv[o]  = 1'b0;
    end
    @(negedge Clk);

    // Reset values, then release and plain traffic (injection on lane 2 every 4th RUN cycle).
    do_reset(1'b0, 3);
    for (int i = 0; i < 16; i++) begin
      rand_link(0);
      step();
    end

    // Lane 3 skew 5 with incrementing symbols; CfgValid held during FLUSH must be ignored.
    cfg(3, 5, 1'b0);
    CfgValid = 1'b1; CfgLane = 4'd1; CfgSkew = W'(7); CfgInvert = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 6) CfgValid = 1'b0;
      for (int l = 0; l < N; l++) LinkIn[l*10 +: 10] = 10'(i + 1);
      ElecIdleIn = '0;
      step();
    end

    // Lane 0 invert: 17C -> 283, then electrical idle on lane 0 -> idle symbol.
    cfg(0, 0, 1'b1);
    LinkIn[9:0] = 10'h17C;
    repeat (10) step();
    ElecIdleIn[0] = 1'b1;
    repeat (3) step();
    ElecIdleIn[0] = 1'b0;

    // Out-of-range lane is accepted and discarded without a FLUSH.
    cfg(15, 3, 1'b1);
    repeat (4) step();

    // Reset in the middle of a FLUSH.
    cfg(1, 2, 1'b1);
    repeat (3) step();
    do_reset(1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      rand_link(4);
      step();
    end

    // Reversal latched through reset; toggling it afterwards has no effect.
    do_reset(1'b1, 2);
    LaneReverse = 1'b0;
    ElecIdleIn  = '0;
    for (int i = 0; i < 6; i++) begin
      rand_link(0);
      LinkIn[9:0] = 10'h0AA;
      step();
    end

    // Randomised soak: config requests, idle flags, error controls, occasional resets.
    for (int i = 0; i < 500; i++) begin
      rand_link(4);
      LaneReverse = 1'($urandom);
      ErrLane     = 4'($urandom_range(N));
      ErrMask     = 10'($urandom);
      CfgValid    = ($urandom_range(5) == 0);
      CfgLane     = 4'($urandom_range(N + 1));
      CfgSkew     = W'($urandom);
      CfgInvert   = 1'($urandom);
      if ($urandom_range(99) == 0) begin
        case ($urandom_range(3))
          0: ErrPeriod = 16'd0;
          1: ErrPeriod = 16'd3;
          2: ErrPeriod = 16'd5;
          default: ErrPeriod = 16'd4;
        endcase
        do_reset(1'($urandom), 1 + $urandom_range(1));
      end else begin
        step();
      end
    end
    CfgValid = 1'b0;
    step();

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
